// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and
// the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bit_1_full_adder.sv
// Single-bit full adder cell: s_i = a_i ^ b_i ^ c_i_1, c_i = carry-out.
module bit_1_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i_1,
  output logic s_i,
  output logic c_i
);

  logic half_sum;

  assign half_sum = a_i ^ b_i;
  assign s_i      = half_sum ^ c_i_1;
  assign c_i      = (a_i & b_i) | (c_i_1 & half_sum);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder controller: computes A+B+c_in one bit per clock, LSB first,
// through a single bit_1_full_adder instance.
//
// Timing: start_i accepted at edge 0; operand bits 0..WIDTH-1 are added on
// edges 1..WIDTH (busy_o high for those WIDTH cycles); edge WIDTH+1 is a settle
// step that loads sum_o/c_out_o from the partial-sum and carry registers and
// raises done_o for one cycle.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add input sub_i, which turns
// the operation into A + ~B + 1 (c_in_i ignored; c_out_o=1 means no borrow).
module bit_serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o
);

  // Counter runs 0..WIDTH: WIDTH add steps plus the settle step.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] psum;
  logic             carry;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             accept;

  // Operand conditioning at acceptance: subtraction stores ~B with carry-in 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub_i ? ~b_i : b_i;
    c_load = sub_i ? 1'b1 : c_in_i;
`else
    b_load = b_i;
    c_load = c_in_i;
`endif
  end

  // New operands are taken from IDLE or, back-to-back, from DONE; never in SHIFT.
  assign accept = start_i && (state == IDLE || state == DONE);

  // The only arithmetic: one full-adder cell fed by the operand LSBs.
  bit_1_full_adder u_fa (
    .a_i   (op_a[0]),
    .b_i   (op_b[0]),
    .c_i_1 (carry),
    .s_i   (sum_bit),
    .c_i   (carry_next)
  );

  // Controller FSM with registered outputs and serial datapath registers.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and partial-sum registers are reset too, so nothing from an
      // aborted operation can surface later.
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      c_out_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        op_a   <= a_i;
        op_b   <= b_load;
        carry  <= c_load;
        psum   <= '0;
        cnt    <= '0;
        busy_o <= 1'b1;
        state  <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            if (cnt == SETTLE) begin
              sum_o   <= psum;
              c_out_o <= carry;
              done_o  <= 1'b1;
              state   <= DONE;
            end else begin
              // Operand registers shift right so op[0] always holds bit[cnt].
              psum  <= {sum_bit, psum[WIDTH-1:1]};
              carry <= carry_next;
              op_a  <= op_a >> 1;
              op_b  <= op_b >> 1;
              cnt   <= cnt + CNT_W'(1);
              if (cnt == LAST_BIT) begin
                busy_o <= 1'b0;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl (WIDTH=8): reset state, a
// vector table, randomized operations against an arithmetic reference model,
// and hand-written sequences for ignored starts, mid-operation reset,
// back-to-back operation and (when SERIAL_ADDER_SUB_EN is defined) subtraction.
module tb_bit_serial_adder_ctrl;

  localparam int W       = 8;
  localparam int LATENCY = W + 1;  // done_o seen after this edge, counted from accept edge 0
  localparam int WINDOW  = W + 4;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         c_in_i;
  logic         sub_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         c_out_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_in_i  (c_in_i),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i   (sub_i),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .c_out_o (c_out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;  // {carry, sum}
  } vec_t;

  typedef struct {
    logic [W:0] res;
    int         done_edge;
    int         busy_cycles;
    int         done_pulses;
    int         sum_changes;
  } obs_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // One operation: start sampled at edge 0, inputs scrambled afterwards,
  // then observe WINDOW further edges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit release_rst, output obs_t o);
    logic [W-1:0] prev;
    o = '{res: '0, done_edge: -1, busy_cycles: 0, done_pulses: 0, sum_changes: 0};
    @(negedge clk);
    a_i = a; b_i = b; c_in_i = cin; sub_i = sub; start_i = 1'b1;
    if (release_rst) rst_n = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = 8'($urandom_range(255)); b_i = 8'($urandom_range(255));
    c_in_i = 1'($urandom_range(1)); sub_i = 1'($urandom_range(1));
    prev = sum_o;
    if (busy_o) o.busy_cycles++;
    for (int k = 1; k <= WINDOW; k++) begin
      @(posedge clk); #1;
      if (busy_o) o.busy_cycles++;
      if (done_o) begin
        if (o.done_pulses == 0) begin
          o.done_edge = k;
          o.res = {c_out_o, sum_o};
        end
        o.done_pulses++;
      end else if (o.done_pulses == 0 && sum_o !== prev) begin
        o.sum_changes++;
      end
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic [W:0] exp);
    check({tag, "_result"}, 32'(o.res), 32'(exp));
    check({tag, "_latency"}, o.done_edge, LATENCY);
    check({tag, "_busy_cycles"}, o.busy_cycles, W);
    check({tag, "_done_pulses"}, o.done_pulses, 1);
    check({tag, "_sum_stable"}, o.sum_changes, 0);
  endtask

  initial begin
    vec_t       vecs[8];
    obs_t       o;
    logic [W-1:0] ra, rb;
    logic       rc, rs;
    int         pulses;
    int         k_done;
    logic [W:0] got;

    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; c_in_i = 1'b0; sub_i = 1'b0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, exp: 9'h010};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: 9'h100};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
    vecs[3] = '{a: 8'h03, b: 8'h04, cin: 1'b0, exp: 9'h007};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp: 9'h000};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: 9'h100};
    vecs[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, exp: 9'h100};
    vecs[7] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, exp: 9'h080};

    // Reset state.
    #12;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_result", {c_out_o, sum_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0, o);
      check_obs($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      rs = HAS_SUB ? 1'($urandom_range(1)) : 1'b0;
      run_op(ra, rb, rc, rs, 1'b0, o);
      check($sformatf("rand%0d_result", i), 32'(o.res), 32'(ref_op(ra, rb, rc, rs)));
      check($sformatf("rand%0d_latency", i), o.done_edge, LATENCY);
    end

    // start_i during SHIFT is ignored: one done_o, original result.
    @(negedge clk);
    a_i = 8'h03; b_i = 8'h04; c_in_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_i = 8'h11; b_i = 8'h22; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignore_busy", busy_o, 1);
    pulses = 0;
    got = '0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(posedge clk); #1;
      if (done_o) begin
        if (pulses == 0) got = {c_out_o, sum_o};
        pulses++;
      end
    end
    check("ignore_done_pulses", pulses, 1);
    check("ignore_result", 32'(got), 32'h007);
    check("ignore_back_idle", busy_o, 0);

    // Reset in the 4th SHIFT cycle aborts; first edge after release accepts.
    @(negedge clk);
    a_i = 8'h55; b_i = 8'h33; c_in_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_pre_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_result", {c_out_o, sum_o}, 0);
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, o);
    check_obs("after_reset", o, 9'h002);

    // Back-to-back: start_i high in the DONE cycle, no IDLE gap.
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; c_in_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k_done = -1;
    for (int k = 1; k <= WINDOW && k_done < 0; k++) begin
      @(posedge clk); #1;
      if (done_o) k_done = k;
    end
    check("b2b_first_latency", k_done, LATENCY);
    check("b2b_first_result", {c_out_o, sum_o}, 9'h046);
    check("b2b_done_not_busy", busy_o, 0);
    a_i = 8'h80; b_i = 8'h80; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("b2b_busy_no_gap", busy_o, 1);
    check("b2b_done_cleared", done_o, 0);
    k_done = -1;
    for (int k = 1; k <= WINDOW && k_done < 0; k++) begin
      @(posedge clk); #1;
      if (done_o) k_done = k;
    end
    check("b2b_second_latency", k_done, LATENCY);
    check("b2b_second_result", {c_out_o, sum_o}, 9'h100);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: A + ~B + 1, carry-in ignored, c_out_o=0 means borrow.
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, o);
    check_obs("sub_5_7", o, 9'h0FE);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, o);
    check("sub_cin_ignored", 32'(o.res), 32'h0FE);
    run_op(8'h09, 8'h04, 1'b0, 1'b1, 1'b0, o);
    check("sub_no_borrow", 32'(o.res), 32'h105);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
